mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_id_fifo.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter.
//   arb_id_e                 : requester identifier stored per outstanding
//                              transaction (instruction fetch or data access)
//   ARB_MAX_OUTSTANDING_DEF  : default number of accepted-but-unanswered
//                              transactions
package mem_port_arbiter_pkg;

  typedef enum logic {
    ARB_ID_INSTR = 1'b0,
    ARB_ID_DATA  = 1'b1
  } arb_id_e;

  localparam int ARB_MAX_OUTSTANDING_DEF = 2;

endpackage

// File: rtl/mem_port_arbiter_id_fifo.sv
// arb_id_fifo: in-order queue of requester IDs for outstanding transactions.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (empties the queue)
//   push, push_id     enqueue one ID (caller never pushes when full)
//   pop               dequeue the head (caller never pops when empty)
//   head_id           ID at the head of the queue
//   full, empty       occupancy flags
// Simultaneous push and pop leaves the occupancy unchanged.
module arb_id_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = ARB_MAX_OUTSTANDING_DEF
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  arb_id_e push_id,
  input  logic    pop,
  output arb_id_e head_id,
  output logic    full,
  output logic    empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  arb_id_e          mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  // Payload storage carries no reset; only pointers/count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_id;
  end

  assign head_id = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a load/store requester.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   instr_req_i/instr_addr_i          fetch request
//   instr_gnt_o/instr_rvalid_o        fetch accept / response strobe
//   data_req_i/we/be/addr/wdata       load/store request
//   data_gnt_o/data_rvalid_o          data accept / response strobe
//   rsp_rdata_o/rsp_err_o             response payload shared by both sides
//   mem_req_o/we/be/addr/wdata        shared memory request
//   mem_gnt_i/rvalid_i/rdata_i/err_i  shared memory handshake and response
// Grants are combinational (zero latency). Up to MAX_OUTSTANDING accepted
// transactions may be waiting for responses, which return in order.
// Optional macro ARB_ROUND_ROBIN_EN: ties go to the requester not granted
// last; without it data always wins a tie.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = ARB_MAX_OUTSTANDING_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i
);

  logic    fifo_full;
  logic    fifo_empty;
  arb_id_e head_id;
  arb_id_e sel;
  logic    lock_vld;
  arb_id_e lock_id;
  logic    handshake;
  logic    pop;
  logic    lock_req;
  logic    tie_to_data;

`ifdef ARB_ROUND_ROBIN_EN
  arb_id_e last_id;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         last_id <= ARB_ID_INSTR;
    else if (handshake) last_id <= sel;
  end

  assign tie_to_data = (last_id == ARB_ID_INSTR);
`else
  assign tie_to_data = 1'b1;
`endif

  // The lock only holds while the locked requester is still asking, so a
  // withdrawn request cannot keep the port pointed at an idle source.
  assign lock_req = (lock_id == ARB_ID_DATA) ? data_req_i : instr_req_i;

  always_comb begin
    sel = ARB_ID_INSTR;
    if (lock_vld && lock_req)           sel = lock_id;
    else if (data_req_i && instr_req_i) sel = tie_to_data ? ARB_ID_DATA : ARB_ID_INSTR;
    else if (data_req_i)                sel = ARB_ID_DATA;
  end

  // rst_n gates the combinational outputs so nothing escapes during reset.
  assign mem_req_o = (instr_req_i | data_req_i) & ~fifo_full & rst_n;
  assign handshake = mem_req_o & mem_gnt_i;
  assign pop       = mem_rvalid_i & ~fifo_empty & rst_n;

  assign instr_gnt_o    = handshake & (sel == ARB_ID_INSTR);
  assign data_gnt_o     = handshake & (sel == ARB_ID_DATA);
  assign instr_rvalid_o = pop & (head_id == ARB_ID_INSTR);
  assign data_rvalid_o  = pop & (head_id == ARB_ID_DATA);
  assign rsp_rdata_o    = mem_rdata_i;
  assign rsp_err_o      = mem_err_i;

  always_comb begin
    mem_we_o    = 1'b0;
    mem_be_o    = 4'hF;
    mem_addr_o  = instr_addr_i;
    mem_wdata_o = '0;
    if (sel == ARB_ID_DATA) begin
      mem_we_o    = data_we_i;
      mem_be_o    = data_be_i;
      mem_addr_o  = data_addr_i;
      mem_wdata_o = data_wdata_i;
    end
  end

  // Held selection while a request waits for the grant; released on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_vld <= 1'b0;
      lock_id  <= ARB_ID_INSTR;
    end else begin
      lock_vld <= mem_req_o & ~mem_gnt_i;
      if (mem_req_o & ~mem_gnt_i) lock_id <= sel;
    end
  end

  arb_id_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (handshake),
    .push_id (sel),
    .pop     (pop),
    .head_id (head_id),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req_i;
  logic [31:0] instr_addr_i;
  logic        instr_gnt_o;
  logic        instr_rvalid_o;
  logic        data_req_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o;
  logic        data_rvalid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_err_i;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_req_i    (instr_req_i),
    .instr_addr_i   (instr_addr_i),
    .instr_gnt_o    (instr_gnt_o),
    .instr_rvalid_o (instr_rvalid_o),
    .data_req_i     (data_req_i),
    .data_we_i      (data_we_i),
    .data_be_i      (data_be_i),
    .data_addr_i    (data_addr_i),
    .data_wdata_i   (data_wdata_i),
    .data_gnt_o     (data_gnt_o),
    .data_rvalid_o  (data_rvalid_o),
    .rsp_rdata_o    (rsp_rdata_o),
    .rsp_err_o      (rsp_err_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_be_o       (mem_be_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_gnt_i      (mem_gnt_i),
    .mem_rvalid_i   (mem_rvalid_i),
    .mem_rdata_i    (mem_rdata_i),
    .mem_err_i      (mem_err_i)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    instr_req_i  = 1'b0;
    instr_addr_i = 32'h0;
    data_req_i   = 1'b0;
    data_we_i    = 1'b0;
    data_be_i    = 4'h0;
    data_addr_i  = 32'h0;
    data_wdata_i = 32'h0;
    mem_gnt_i    = 1'b0;
    mem_rvalid_i = 1'b0;
    mem_rdata_i  = 32'h0;
    mem_err_i    = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    // Reset: requests and responses present, outputs must stay quiet.
    instr_req_i  = 1'b1;
    mem_gnt_i    = 1'b1;
    mem_rvalid_i = 1'b1;
    settle();
    chk("rst_mem_req",      32'(mem_req_o),      32'h0);
    chk("rst_instr_gnt",    32'(instr_gnt_o),    32'h0);
    chk("rst_data_gnt",     32'(data_gnt_o),     32'h0);
    chk("rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("rst_data_rvalid",  32'(data_rvalid_o),  32'h0);
    tick();
    tick();
    idle_inputs();
    rst_n = 1'b1;
    tick();

    // Tie with grant: data wins under both arbitration modes (pointer=instr).
    instr_req_i  = 1'b1; instr_addr_i = 32'h100;
    data_req_i   = 1'b1; data_addr_i  = 32'h200;
    data_we_i    = 1'b1; data_be_i    = 4'h3; data_wdata_i = 32'hDEAD;
    mem_gnt_i    = 1'b1;
    settle();
    chk("tie_data_gnt",  32'(data_gnt_o),  32'h1);
    chk("tie_instr_gnt", 32'(instr_gnt_o), 32'h0);
    chk("tie_addr",      mem_addr_o,       32'h200);
    chk("tie_we",        32'(mem_we_o),    32'h1);
    chk("tie_be",        32'(mem_be_o),    32'h3);
    chk("tie_wdata",     mem_wdata_o,      32'hDEAD);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55;
    settle();
    chk("drain_data_rvalid",  32'(data_rvalid_o),  32'h1);
    chk("drain_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("drain_rdata",        rsp_rdata_o,         32'h55);
    tick();
    idle_inputs();

    // Lock: instr waits 3 cycles without grant, data rises in cycle 2.
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    settle();
    chk("lock_c1_req",  32'(mem_req_o),   32'h1);
    chk("lock_c1_addr", mem_addr_o,       32'h100);
    chk("lock_c1_gnt",  32'(instr_gnt_o), 32'h0);
    tick();
    data_req_i = 1'b1; data_addr_i = 32'h200; data_we_i = 1'b1; data_be_i = 4'hC;
    settle();
    chk("lock_c2_addr",     mem_addr_o,      32'h100);
    chk("lock_c2_data_gnt", 32'(data_gnt_o), 32'h0);
    tick();
    settle();
    chk("lock_c3_addr", mem_addr_o, 32'h100);
    chk("lock_c3_we",   32'(mem_we_o), 32'h0);
    tick();
    mem_gnt_i = 1'b1;
    settle();
    chk("lock_gnt_instr", 32'(instr_gnt_o), 32'h1);
    chk("lock_gnt_data",  32'(data_gnt_o),  32'h0);
    chk("lock_gnt_addr",  mem_addr_o,       32'h100);
    chk("fetch_be",       32'(mem_be_o),    32'hF);
    chk("fetch_wdata",    mem_wdata_o,      32'h0);
    tick();
    instr_req_i = 1'b0;
    settle();
    chk("after_lock_data_gnt", 32'(data_gnt_o), 32'h1);
    chk("after_lock_addr",     mem_addr_o,      32'h200);
    chk("after_lock_be",       32'(mem_be_o),   32'hC);
    tick();

    // Two outstanding (instr, data): full blocks requests even with a pop.
    idle_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h300; mem_gnt_i = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA;
    settle();
    chk("full_mem_req",      32'(mem_req_o),      32'h0);
    chk("full_instr_gnt",    32'(instr_gnt_o),    32'h0);
    chk("rsp1_instr_rvalid", 32'(instr_rvalid_o), 32'h1);
    chk("rsp1_data_rvalid",  32'(data_rvalid_o),  32'h0);
    chk("rsp1_rdata",        rsp_rdata_o,         32'hA);
    tick();
    mem_rdata_i = 32'hB;
    settle();
    chk("resume_mem_req",    32'(mem_req_o),      32'h1);
    chk("resume_instr_gnt",  32'(instr_gnt_o),    32'h1);
    chk("rsp2_data_rvalid",  32'(data_rvalid_o),  32'h1);
    chk("rsp2_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("rsp2_rdata",        rsp_rdata_o,         32'hB);
    tick();
    // Push and pop together left one (instr) entry outstanding.
    idle_inputs();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hC; mem_err_i = 1'b1;
    settle();
    chk("rsp3_instr_rvalid", 32'(instr_rvalid_o), 32'h1);
    chk("rsp3_err",          32'(rsp_err_o),      32'h1);
    tick();
    mem_err_i = 1'b0;
    settle();
    chk("empty_stray_instr", 32'(instr_rvalid_o), 32'h0);
    chk("empty_stray_data",  32'(data_rvalid_o),  32'h0);
    tick();

    // Reset mid-transaction discards the outstanding ID.
    idle_inputs();
    instr_req_i = 1'b1; instr_addr_i = 32'h400; mem_gnt_i = 1'b1;
    tick();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    mem_rvalid_i = 1'b1;
    settle();
    chk("post_rst_instr_rvalid", 32'(instr_rvalid_o), 32'h0);
    chk("post_rst_data_rvalid",  32'(data_rvalid_o),  32'h0);
    tick();
    // Queue must be empty: exactly two grants fit before it fills.
    idle_inputs();
    instr_req_i = 1'b1; mem_gnt_i = 1'b1;
    settle();
    chk("post_rst_gnt1", 32'(instr_gnt_o), 32'h1);
    tick();
    settle();
    chk("post_rst_gnt2", 32'(instr_gnt_o), 32'h1);
    tick();
    settle();
    chk("post_rst_full", 32'(mem_req_o), 32'h0);
    tick();
    idle_inputs();
    mem_rvalid_i = 1'b1;
    tick();
    tick();
    idle_inputs();

    // Both requesting continuously; rvalid each cycle keeps the queue at one.
    instr_req_i = 1'b1; data_req_i = 1'b1; mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic exp_data;
`ifdef ARB_ROUND_ROBIN_EN
      exp_data = (i % 2 == 0);
`else
      exp_data = 1'b1;
`endif
      settle();
      chk($sformatf("arb%0d_data_gnt", i),  32'(data_gnt_o),  32'(exp_data));
      chk($sformatf("arb%0d_instr_gnt", i), 32'(instr_gnt_o), 32'(!exp_data));
      tick();
    end
    idle_inputs();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
